// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared encodings and BCD constants for the serial BCD adder.
package bcd_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// Single-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] digit4,
    output logic       co
);

    logic [4:0] s;
    logic [4:0] s_corr;

    assign s      = {1'b0, a4} + {1'b0, b4} + {4'd0, ci};
    assign s_corr = s + {1'b0, BCD_CORR};

    // Invalid input digits follow the same rule; only the low nibble is kept.
    always_comb begin
        digit4 = s[3:0];
        co     = 1'b0;
        if (s > {1'b0, BCD_MAX}) begin
            digit4 = s_corr[3:0];
            co     = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Serial BCD adder sequencer: one shared digit adder, LSD first, start/busy/done.
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] op_a;
    logic [4*DIGITS-1:0] op_b;
    logic                carry;
    logic [3:0]          a_d;
    logic [3:0]          b_d;
    logic [3:0]          digit;
    logic                dco;
    logic                last;

    assign a_d  = op_a[4*idx +: 4];
    assign b_d  = op_b[4*idx +: 4];
    assign last = (idx == IDX_W'(DIGITS - 1));
    assign busy = (state == ST_ADD);
    assign done = (state == ST_DONE);

    bcd_digit_add u_digit (
        .a4     (a_d),
        .b4     (b_d),
        .ci     (carry),
        .digit4 (digit),
        .co     (dco)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_ADD;
            ST_ADD:  if (last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ST_ADD: begin
                    sum[4*idx +: 4] <= digit;
                    carry           <= dco;
                    err             <= err | (a_d > BCD_MAX) | (b_d > BCD_MAX);
                    if (last) begin
                        cout <= dco;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for the serial BCD adder with directed vectors.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        e;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("err", 32'(err), 32'(e.e));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es,
                          input logic ec, input logic ee);
        int nb;
        int t;
        @(negedge clk);
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        sb.push_back('{es, ec, ee, cyc + DIGITS + 1});
        @(negedge clk);
        start = 1'b0;
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        nb = 0;
        t = 0;
        while (done !== 1'b1 && t < 20) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t < 20), 32'd1);
        chk("busy_cycles", 32'(nb), 32'(DIGITS));
    endtask

    initial begin
        int c0;
        int t;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_hold", 32'(err), 32'd1);
        chk("sum_hold", 32'(sum), 32'h0100);
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);

        // Held start: two back-to-back ops, operands disturbed mid-ADD.
        @(negedge clk);
        c0 = cyc;
        a = 16'h0005;
        b = 16'h0005;
        cin = 1'b0;
        start = 1'b1;
        sb.push_back('{16'h0010, 1'b0, 1'b0, c0 + DIGITS + 1});
        sb.push_back('{16'h0010, 1'b0, 1'b0, c0 + 2 * DIGITS + 3});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2 || i == 8) begin
                a = 16'h9999;
                b = 16'h8888;
                cin = 1'b1;
            end
            if (i == 5 || i == 9) begin
                a = 16'h0005;
                b = 16'h0005;
                cin = 1'b0;
            end
        end
        start = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("hold_drain", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);

        // Reset during the second ADD cycle discards the operation.
        a = 16'h4321;
        b = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
